icache_req_seq: RTL and testbench

- Parametrised request sequencer that replaces hard-coded per-tick stimulus in front of the instruction cache.
- Generates a programmable stream of fetch addresses and holds each request until the cache completes it.
- Classifies each completion as hit or miss, counts both, and optionally checks fetched data against an uncached reference port.
- Sits between the simulation top and ICache; drives the i_addr / i_rd inputs and observes o_inst / o_busy / o_hit.

---
 rtl/icache_req_seq.sv | 273 +++++++++++++++++++++++++++
 tb/tb_icache_req_seq.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_req_seq.sv
// ---------------------------------------------------------------------------
// icache_req_seq
//
// Request sequencer placed in front of the instruction cache. It generates a
// programmable stream of fetch addresses (linear, LFSR random or repeated
// base), holds each request stable until the cache completes it, classifies
// every completion as a hit or a miss and counts both. A per-request watchdog
// aborts the run if the cache never answers.
//
// Optional feature (compile-time macro ICACHE_REQ_SEQ_CHECK_EN):
//   When defined, an extra input i_ref_inst carries the instruction read from
//   an uncached reference ROM port addressed by o_addr. Every completion whose
//   i_inst differs from i_ref_inst increments o_errors. When undefined, the
//   port does not exist and o_errors is tied to zero.
//
// Ports:
//   i_clock    clock
//   i_reset    synchronous, active-high reset
//   i_start    start a run (honoured in IDLE and DONE only)
//   i_mode     0=linear, 1=LFSR random, 2=repeat base, 3=linear
//   i_base     first address of the run
//   i_stride   linear-mode increment
//   i_count    number of requests in the run (0 finishes immediately)
//   o_addr     fetch address to the cache
//   o_rd       read request to the cache
//   i_busy     cache busy (line fill in progress)
//   i_hit      cache output valid for o_addr
//   i_inst     instruction from the cache
//   i_ref_inst reference instruction (only with ICACHE_REQ_SEQ_CHECK_EN)
//   o_done     run finished, held until the next start
//   o_timeout  run aborted on timeout, held with o_done
//   o_hits     completed requests that never saw busy
//   o_misses   completed requests that saw busy at least once
//   o_errors   data mismatches against the reference port
// ---------------------------------------------------------------------------
module icache_req_seq #(
  parameter int          ADDR_WIDTH = 12,
  parameter int          DATA_WIDTH = 32,
  parameter int          CNT_WIDTH  = 16,
  parameter int          GAP_CYCLES = 4,
  parameter int          TIMEOUT    = 255,
  parameter logic [31:0] LFSR_SEED  = 32'h0000_0ACE
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [1:0]            i_mode,
  input  logic [ADDR_WIDTH-1:0] i_base,
  input  logic [ADDR_WIDTH-1:0] i_stride,
  input  logic [CNT_WIDTH-1:0]  i_count,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_rd,
  input  logic                  i_busy,
  input  logic                  i_hit,
  input  logic [DATA_WIDTH-1:0] i_inst,
`ifdef ICACHE_REQ_SEQ_CHECK_EN
  input  logic [DATA_WIDTH-1:0] i_ref_inst,
`endif
  output logic                  o_done,
  output logic                  o_timeout,
  output logic [CNT_WIDTH-1:0]  o_hits,
  output logic [CNT_WIDTH-1:0]  o_misses,
  output logic [CNT_WIDTH-1:0]  o_errors
);

  // Galois (right-shift) feedback masks for maximal-length LFSRs. Bit n-1 is
  // always part of the mask so the register keeps its full width; the other
  // bits come from the classic tap tables. Widths without a table entry get
  // a simple non-zero mask so the register can still never reach zero.
  function automatic logic [63:0] lfsr_taps(input int width);
    logic [63:0] taps;
    case (width)
      2:       taps = 64'h3;
      3:       taps = 64'h6;
      4:       taps = 64'hC;
      5:       taps = 64'h14;
      6:       taps = 64'h30;
      7:       taps = 64'h60;
      8:       taps = 64'hB8;
      9:       taps = 64'h110;
      10:      taps = 64'h240;
      11:      taps = 64'h500;
      12:      taps = 64'h829;
      13:      taps = 64'h100D;
      14:      taps = 64'h2015;
      15:      taps = 64'h6000;
      16:      taps = 64'hD008;
      default: taps = (64'd1 << (width - 1)) | 64'd1;
    endcase
    return taps;
  endfunction

  localparam logic [ADDR_WIDTH-1:0] LFSR_TAPS  = ADDR_WIDTH'(lfsr_taps(ADDR_WIDTH));
  localparam logic [ADDR_WIDTH-1:0] SEED_TRUNC = ADDR_WIDTH'(LFSR_SEED);
  // A zero seed would lock the LFSR at zero forever, so fall back to 1.
  localparam logic [ADDR_WIDTH-1:0] LFSR_INIT  =
    (SEED_TRUNC == '0) ? ADDR_WIDTH'(1) : SEED_TRUNC;

  localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [TO_W-1:0]      TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0]     GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  localparam logic [1:0] MODE_LFSR   = 2'd1;
  localparam logic [1:0] MODE_REPEAT = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_GAP,
    ST_DONE
  } state_t;

  state_t                  state;
  logic [1:0]              mode_q;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic [ADDR_WIDTH-1:0]   stride_q;
  logic [CNT_WIDTH-1:0]    remaining;
  logic [ADDR_WIDTH-1:0]   lfsr;
  logic                    busy_seen;
  logic [TO_W-1:0]         to_cnt;
  logic [GAP_W-1:0]        gap_cnt;

  logic                    launch;
  logic                    complete;
  logic [ADDR_WIDTH-1:0]   lfsr_next;
  logic [ADDR_WIDTH-1:0]   next_addr;

  // A start is honoured only while no run is in flight; from DONE it
  // restarts in the same cycle exactly as from IDLE.
  assign launch = i_start && ((state == ST_IDLE) || (state == ST_DONE));

  // The cache has answered the current request once it reports a valid
  // output while no fill is in progress.
  assign complete = (state == ST_REQ) && i_hit && !i_busy;

  // Next-address generation. The LFSR is a separate register so that it
  // keeps evolving across runs; only a reset returns it to the seed.
  always_comb begin
    lfsr_next = lfsr >> 1;
    if (lfsr[0]) begin
      lfsr_next = (lfsr >> 1) ^ LFSR_TAPS;
    end
    case (mode_q)
      MODE_LFSR:   next_addr = lfsr_next;
      MODE_REPEAT: next_addr = base_q;
      default:     next_addr = o_addr + stride_q;
    endcase
  end

`ifdef ICACHE_REQ_SEQ_CHECK_EN
  logic [CNT_WIDTH-1:0] errors;
  assign o_errors = errors;
`else
  // Without the reference port there is nothing to compare i_inst against.
  logic unused_inst;
  assign unused_inst = ^i_inst;
  assign o_errors    = '0;
`endif

  // Main sequencer: every output is a register written here. Statistics
  // counters saturate at all-ones rather than wrapping.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state     <= ST_IDLE;
      o_rd      <= 1'b0;
      o_addr    <= '0;
      o_done    <= 1'b0;
      o_timeout <= 1'b0;
      o_hits    <= '0;
      o_misses  <= '0;
      mode_q    <= '0;
      base_q    <= '0;
      stride_q  <= '0;
      remaining <= '0;
      lfsr      <= LFSR_INIT;
      busy_seen <= 1'b0;
      to_cnt    <= '0;
      gap_cnt   <= '0;
`ifdef ICACHE_REQ_SEQ_CHECK_EN
      errors    <= '0;
`endif
    end else if (launch) begin
      o_hits    <= '0;
      o_misses  <= '0;
      o_timeout <= 1'b0;
      mode_q    <= i_mode;
      base_q    <= i_base;
      stride_q  <= i_stride;
      remaining <= i_count;
      o_addr    <= i_base;
      busy_seen <= 1'b0;
      to_cnt    <= '0;
      gap_cnt   <= '0;
`ifdef ICACHE_REQ_SEQ_CHECK_EN
      errors    <= '0;
`endif
      if (i_count == '0) begin
        state  <= ST_DONE;
        o_done <= 1'b1;
        o_rd   <= 1'b0;
      end else begin
        state  <= ST_REQ;
        o_done <= 1'b0;
        o_rd   <= 1'b1;
      end
    end else begin
      case (state)
        ST_REQ: begin
          if (complete) begin
            if (busy_seen) begin
              if (o_misses != '1) o_misses <= o_misses + CNT_ONE;
            end else begin
              if (o_hits != '1) o_hits <= o_hits + CNT_ONE;
            end
`ifdef ICACHE_REQ_SEQ_CHECK_EN
            if ((i_inst != i_ref_inst) && (errors != '1)) begin
              errors <= errors + CNT_ONE;
            end
`endif
            busy_seen <= 1'b0;
            to_cnt    <= '0;
            remaining <= remaining - CNT_ONE;
            if (remaining == CNT_ONE) begin
              state  <= ST_DONE;
              o_done <= 1'b1;
              o_rd   <= 1'b0;
            end else begin
              o_addr <= next_addr;
              if (mode_q == MODE_LFSR) lfsr <= lfsr_next;
              if (GAP_CYCLES == 0) begin
                state <= ST_REQ;
                o_rd  <= 1'b1;
              end else begin
                state   <= ST_GAP;
                o_rd    <= 1'b0;
                gap_cnt <= '0;
              end
            end
          end else begin
            // The busy flag is sticky for the life of the request so that a
            // fill seen early still classifies the completion as a miss.
            if (i_busy) busy_seen <= 1'b1;
            if (to_cnt == TO_LAST) begin
              state     <= ST_DONE;
              o_done    <= 1'b1;
              o_timeout <= 1'b1;
              o_rd      <= 1'b0;
            end else begin
              to_cnt <= to_cnt + TO_W'(1);
            end
          end
        end

        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= ST_REQ;
            o_rd  <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        default: begin
          o_rd <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_req_seq.sv
// ---------------------------------------------------------------------------
// tb_icache_req_seq
//
// Directed bench for icache_req_seq. A small behavioural cache with 8-word
// lines and a 4-cycle fill answers the sequencer; a bench-side flag can pin
// i_busy high and another can corrupt one cached word. Expected values are
// hand-computed constants in each test task.
// ---------------------------------------------------------------------------
module tb_icache_req_seq;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int CW = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    mode = '0;
  logic [AW-1:0] base = '0;
  logic [AW-1:0] stride = '0;
  logic [CW-1:0] count = '0;
  logic [AW-1:0] addr;
  logic          rd;
  logic          busy;
  logic          hit;
  logic [DW-1:0] inst;
  logic [DW-1:0] ref_inst;
  logic          done;
  logic          tout;
  logic [CW-1:0] hits;
  logic [CW-1:0] misses;
  logic [CW-1:0] errors;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  icache_req_seq #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW),
    .GAP_CYCLES(4),
    .TIMEOUT   (20),
    .LFSR_SEED (32'h0000_0ACE)
  ) dut (
    .i_clock   (clock),
    .i_reset   (reset),
    .i_start   (start),
    .i_mode    (mode),
    .i_base    (base),
    .i_stride  (stride),
    .i_count   (count),
    .o_addr    (addr),
    .o_rd      (rd),
    .i_busy    (busy),
    .i_hit     (hit),
    .i_inst    (inst),
`ifdef ICACHE_REQ_SEQ_CHECK_EN
    .i_ref_inst(ref_inst),
`endif
    .o_done    (done),
    .o_timeout (tout),
    .o_hits    (hits),
    .o_misses  (misses),
    .o_errors  (errors)
  );

  // Behavioural cache: a line is either valid (hit this cycle) or being
  // filled (busy) for 4 cycles after the request first lands on it.
  logic          line_valid [0:511];
  int            fill_cnt = 0;
  logic          flush_req = 1'b0;
  logic          force_busy = 1'b0;
  logic          corrupt_en = 1'b0;
  logic [AW-1:0] corrupt_addr = 12'h013;

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return {8'hC3, 4'h0, a, 8'h5A};
  endfunction

  always_comb begin
    busy     = force_busy || (rd && !line_valid[addr[11:3]]);
    hit      = rd && line_valid[addr[11:3]] && !force_busy;
    ref_inst = rom_word(addr);
    inst     = ref_inst ^ ((corrupt_en && (addr == corrupt_addr)) ? 32'h1 : 32'h0);
  end

  always @(posedge clock) begin
    if (flush_req) begin
      for (int i = 0; i < 512; i++) line_valid[i] <= 1'b0;
      fill_cnt <= 0;
    end else if (rd && !force_busy && !line_valid[addr[11:3]]) begin
      if (fill_cnt == 3) begin
        line_valid[addr[11:3]] <= 1'b1;
        fill_cnt <= 0;
      end else begin
        fill_cnt <= fill_cnt + 1;
      end
    end
  end

  // Observations collected by run_seq, all written only from the main
  // initial block.
  logic [AW-1:0] done_addrs[$];
  int            rd_cycles;
  int            run_cycles;
  int            addr_bad;
  logic          watch_en = 1'b0;
  logic [AW-1:0] watch_addr = '0;
  logic          first_done;
  logic          first_rd;

  task automatic flush_cache();
    @(negedge clock);
    flush_req = 1'b1;
    @(negedge clock);
    flush_req = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Pulse start for one cycle, then follow the run until o_done, recording
  // request cycles, completion addresses and address stability.
  task automatic run_seq(input logic [1:0] m, input logic [AW-1:0] b,
                         input logic [AW-1:0] s, input logic [CW-1:0] n);
    logic finished;
    finished = 1'b0;
    done_addrs.delete();
    rd_cycles  = 0;
    run_cycles = 0;
    addr_bad   = 0;
    @(negedge clock);
    mode   = m;
    base   = b;
    stride = s;
    count  = n;
    start  = 1'b1;
    @(negedge clock);
    start      = 1'b0;
    first_done = done;
    first_rd   = rd;
    for (int c = 0; c < 3000; c++) begin
      if (rd) begin
        rd_cycles++;
        if (watch_en && (addr != watch_addr)) addr_bad++;
        if (hit && !busy) done_addrs.push_back(addr);
      end
      if (done) begin
        run_cycles = c;
        finished   = 1'b1;
        break;
      end
      @(negedge clock);
    end
    total++;
    if (!finished) begin
      bad++;
      $display("[TB] FAIL run_timeout: o_done=%b after 3000 cycles, required 1", done);
    end
  endtask

  task automatic test_reset();
    flush_cache();
    apply_reset();
    reset = 1'b1;
    @(negedge clock);
    total++;
    if ({rd, done, tout} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL reset_flags: rd/done/timeout=%b required 000", {rd, done, tout});
    end
    total++;
    if (addr !== 12'h000) begin
      bad++;
      $display("[TB] FAIL reset_addr: got %h required 000", addr);
    end
    total++;
    if ({hits, misses, errors} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_counters: hits=%0d misses=%0d errors=%0d required 0", hits, misses, errors);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_lfsr();
    logic [AW-1:0] exp_addr [3];
    logic [AW-1:0] got;
    exp_addr = '{12'h000, 12'h567, 12'hA9A};
    apply_reset();
    flush_cache();
    run_seq(2'd1, 12'h000, 12'h000, 16'd3);
    for (int i = 0; i < 3; i++) begin
      got = (i < done_addrs.size()) ? done_addrs[i] : 'x;
      total++;
      if (got !== exp_addr[i]) begin
        bad++;
        $display("[TB] FAIL lfsr_addr%0d: got %h required %h", i, got, exp_addr[i]);
      end
    end
    total++;
    if ({hits, misses} !== {16'd0, 16'd3}) begin
      bad++;
      $display("[TB] FAIL lfsr_counts: hits=%0d misses=%0d required 0/3", hits, misses);
    end
  endtask

  task automatic test_linear();
    flush_cache();
    run_seq(2'd0, 12'h010, 12'h001, 16'd8);
    total++;
    if (done_addrs.size() != 8) begin
      bad++;
      $display("[TB] FAIL linear_completions: got %0d required 8", done_addrs.size());
    end
    total++;
    if ({hits, misses} !== {16'd7, 16'd1}) begin
      bad++;
      $display("[TB] FAIL linear_counts: hits=%0d misses=%0d required 7/1", hits, misses);
    end
    total++;
    if ({done, tout} !== 2'b10) begin
      bad++;
      $display("[TB] FAIL linear_done: done/timeout=%b required 10", {done, tout});
    end
    total++;
    if ((done_addrs.size() != 8) || (done_addrs[7] !== 12'h017)) begin
      bad++;
      $display("[TB] FAIL linear_last_addr: got %h required 017",
               (done_addrs.size() == 8) ? done_addrs[7] : 12'hxxx);
    end
    total++;
    if (rd_cycles != 12) begin
      bad++;
      $display("[TB] FAIL linear_rd_cycles: got %0d required 12", rd_cycles);
    end
    total++;
    if (run_cycles != 40) begin
      bad++;
      $display("[TB] FAIL linear_run_cycles: got %0d required 40", run_cycles);
    end
`ifndef ICACHE_REQ_SEQ_CHECK_EN
    total++;
    if (errors !== 16'd0) begin
      bad++;
      $display("[TB] FAIL linear_errors: got %0d required 0", errors);
    end
`endif
  endtask

  task automatic test_repeat();
    flush_cache();
    watch_en   = 1'b1;
    watch_addr = 12'h011;
    run_seq(2'd2, 12'h011, 12'h005, 16'd5);
    watch_en = 1'b0;
    total++;
    if ({hits, misses} !== {16'd4, 16'd1}) begin
      bad++;
      $display("[TB] FAIL repeat_counts: hits=%0d misses=%0d required 4/1", hits, misses);
    end
    total++;
    if (addr_bad != 0) begin
      bad++;
      $display("[TB] FAIL repeat_addr_stable: %0d rd cycles off 011, required 0", addr_bad);
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] exp_addr [3];
    logic [AW-1:0] got;
    exp_addr = '{12'hFF0, 12'h000, 12'h010};
    flush_cache();
    run_seq(2'd0, 12'hFF0, 12'h010, 16'd3);
    for (int i = 0; i < 3; i++) begin
      got = (i < done_addrs.size()) ? done_addrs[i] : 'x;
      total++;
      if (got !== exp_addr[i]) begin
        bad++;
        $display("[TB] FAIL wrap_addr%0d: got %h required %h", i, got, exp_addr[i]);
      end
    end
    total++;
    if ({hits, misses} !== {16'd0, 16'd3}) begin
      bad++;
      $display("[TB] FAIL wrap_counts: hits=%0d misses=%0d required 0/3", hits, misses);
    end
  endtask

  task automatic test_mode3();
    flush_cache();
    run_seq(2'd3, 12'h020, 12'h002, 16'd3);
    total++;
    if ((done_addrs.size() != 3) || (done_addrs[2] !== 12'h024)) begin
      bad++;
      $display("[TB] FAIL mode3_last_addr: got %h required 024",
               (done_addrs.size() == 3) ? done_addrs[2] : 12'hxxx);
    end
    total++;
    if ({hits, misses} !== {16'd2, 16'd1}) begin
      bad++;
      $display("[TB] FAIL mode3_counts: hits=%0d misses=%0d required 2/1", hits, misses);
    end
  endtask

  task automatic test_timeout();
    force_busy = 1'b1;
    run_seq(2'd0, 12'h100, 12'h001, 16'd2);
    force_busy = 1'b0;
    total++;
    if (rd_cycles != 20) begin
      bad++;
      $display("[TB] FAIL timeout_req_cycles: got %0d required 20", rd_cycles);
    end
    total++;
    if ({done, tout} !== 2'b11) begin
      bad++;
      $display("[TB] FAIL timeout_flags: done/timeout=%b required 11", {done, tout});
    end
    total++;
    if ({hits, misses} !== '0) begin
      bad++;
      $display("[TB] FAIL timeout_counts: hits=%0d misses=%0d required 0/0", hits, misses);
    end
  endtask

  task automatic test_count_zero();
    logic rd_seen;
    @(negedge clock);
    mode  = 2'd0;
    base  = 12'h200;
    count = 16'd0;
    start = 1'b1;
    @(negedge clock);
    start   = 1'b0;
    rd_seen = rd;
    total++;
    if ({done, tout} !== 2'b10) begin
      bad++;
      $display("[TB] FAIL zero_done: done/timeout=%b required 10", {done, tout});
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (rd) rd_seen = 1'b1;
    end
    total++;
    if (rd_seen !== 1'b0) begin
      bad++;
      $display("[TB] FAIL zero_rd: rd seen=%b required 0", rd_seen);
    end
  endtask

  task automatic test_back_to_back();
    flush_cache();
    run_seq(2'd2, 12'h011, 12'h000, 16'd2);
    total++;
    if ({first_done, first_rd} !== 2'b01) begin
      bad++;
      $display("[TB] FAIL restart_from_done: done/rd=%b required 01", {first_done, first_rd});
    end
    total++;
    if ({hits, misses} !== {16'd1, 16'd1}) begin
      bad++;
      $display("[TB] FAIL restart_counts: hits=%0d misses=%0d required 1/1", hits, misses);
    end
  endtask

  task automatic test_reset_in_gap();
    logic in_gap;
    in_gap = 1'b0;
    flush_cache();
    @(negedge clock);
    mode   = 2'd0;
    base   = 12'h040;
    stride = 12'h001;
    count  = 16'd4;
    start  = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (((hits + misses) != 0) && !rd && !done) begin
        in_gap = 1'b1;
        break;
      end
      @(negedge clock);
    end
    total++;
    if (!in_gap) begin
      bad++;
      $display("[TB] FAIL gap_reached: got 0 required 1");
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    total++;
    if ({rd, done, tout} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL gap_reset_flags: rd/done/timeout=%b required 000", {rd, done, tout});
    end
    total++;
    if ({hits, misses, addr} !== '0) begin
      bad++;
      $display("[TB] FAIL gap_reset_state: hits=%0d misses=%0d addr=%h required 0/0/000",
               hits, misses, addr);
    end
    repeat (6) @(negedge clock);
    total++;
    if ({rd, done} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL gap_reset_idle: rd/done=%b required 00", {rd, done});
    end
  endtask

`ifdef ICACHE_REQ_SEQ_CHECK_EN
  task automatic test_check_errors();
    flush_cache();
    corrupt_en = 1'b1;
    run_seq(2'd0, 12'h010, 12'h001, 16'd8);
    corrupt_en = 1'b0;
    total++;
    if (errors !== 16'd1) begin
      bad++;
      $display("[TB] FAIL check_errors: got %0d required 1", errors);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_lfsr();
    test_linear();
    test_repeat();
    test_wrap();
    test_mode3();
    test_timeout();
    test_count_zero();
    test_back_to_back();
    test_reset_in_gap();
`ifdef ICACHE_REQ_SEQ_CHECK_EN
    test_check_errors();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
